// File: rtl/pwm_ram_scheduler.sv
// Shares the single-port ebr8x16 RAM between the SPI slave and a PWM on-time fetcher.
// Fetched words are collected in a shadow copy, then published to the PWM compare all at once.
module pwm_ram_scheduler #(
    parameter int         NUM_CH    = 3,
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         MAX_WAIT  = 4
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 frame_tick,
    input  logic                 spi_req,
    input  logic                 spi_we,
    input  logic [7:0]           spi_addr,
    input  logic [15:0]          spi_wdata,
    output logic                 spi_gnt,
    output logic                 spi_rvalid,
    output logic [15:0]          spi_rdata,
    output logic                 ram_clk_en,
    output logic                 ram_wr_en,
    output logic [7:0]           ram_addr,
    output logic [15:0]          ram_wr_data,
    input  logic [15:0]          ram_rd_data,
    output logic [NUM_CH*16-1:0] pwm_on_times,
    output logic                 refresh_busy,
    output logic                 refresh_done,
    output logic                 overrun
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [3:0]        LAST_IDX = 4'(NUM_CH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           idx_tag_q, idx_tag_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [NUM_CH*16-1:0] shadow_q, shadow_d;
    logic [NUM_CH*16-1:0] pwm_q, pwm_d;
    logic                 spi_rvalid_q, spi_rvalid_d;
    logic                 fetch_tag_q, fetch_tag_d;
    logic                 done_q, done_d;

    logic       fetch_want;
    logic       fetch_forced;
    logic       fetch_gnt;
    logic [7:0] fetch_addr;

    // SPI has priority unless the fetcher has already been starved MAX_WAIT cycles in a row.
    always_comb begin
        fetch_want   = (state_q == FETCH);
        fetch_forced = fetch_want && (wait_cnt_q == WAIT_LIM);
        spi_gnt      = spi_req && !fetch_forced && !reset_in;
        fetch_gnt    = fetch_want && !spi_gnt && !reset_in;
        fetch_addr   = BASE_ADDR + 8'(idx_q);

        ram_clk_en  = spi_gnt || fetch_gnt;
        ram_wr_en   = spi_gnt && spi_we;
        ram_addr    = spi_gnt ? spi_addr : (fetch_gnt ? fetch_addr : 8'h00);
        ram_wr_data = (spi_gnt && spi_we) ? spi_wdata : 16'h0000;

        spi_rvalid   = spi_rvalid_q;
        spi_rdata    = spi_rvalid_q ? ram_rd_data : 16'h0000;
        pwm_on_times = pwm_q;
        refresh_busy = (state_q != IDLE);
        refresh_done = done_q;
        overrun      = frame_tick && (state_q != IDLE);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (frame_tick) begin
                    state_d = FETCH;
                    idx_d   = 4'd0;
                end
            end
            FETCH: begin
                if (fetch_gnt) begin
                    wait_cnt_d = '0;
                    idx_d      = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) state_d = DRAIN;
                end else if (spi_gnt) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Returned read data goes to whoever issued the read one cycle earlier.
    always_comb begin
        spi_rvalid_d = spi_gnt && !spi_we;
        fetch_tag_d  = fetch_gnt;
        idx_tag_d    = idx_q;
        shadow_d     = shadow_q;
        pwm_d        = pwm_q;
        done_d       = 1'b0;
        if (fetch_tag_q) begin
            shadow_d[{idx_tag_q, 4'b0000} +: 16] = ram_rd_data;
            if (idx_tag_q == LAST_IDX) begin
                pwm_d  = shadow_d;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            idx_tag_q    <= 4'd0;
            wait_cnt_q   <= '0;
            shadow_q     <= '0;
            pwm_q        <= '0;
            spi_rvalid_q <= 1'b0;
            fetch_tag_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            idx_tag_q    <= idx_tag_d;
            wait_cnt_q   <= wait_cnt_d;
            shadow_q     <= shadow_d;
            pwm_q        <= pwm_d;
            spi_rvalid_q <= spi_rvalid_d;
            fetch_tag_q  <= fetch_tag_d;
            done_q       <= done_d;
        end
    end

endmodule
